// File: rtl/pipe_latch_if.sv
// Handshake bundle for pipe_latch: upstream valid/ready entry port, downstream head port,
// freeze/flush controls and occupancy.
interface pipe_latch_if #(
    parameter int WIDTH = 96,
    parameter int LANES = 1
);
    logic                     valid_i;
    logic                     ready_o;
    logic [WIDTH*LANES-1:0]   data_i;
    logic [LANES-1:0]         lane_valid_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [WIDTH*LANES-1:0]   data_o;
    logic [LANES-1:0]         lane_valid_o;
    logic                     freeze;
    logic                     flush;
    logic [1:0]               count_o;

    modport master (
        output valid_i, data_i, lane_valid_i, ready_i, freeze, flush,
        input  ready_o, valid_o, data_o, lane_valid_o, count_o
    );

    modport slave (
        input  valid_i, data_i, lane_valid_i, ready_i, freeze, flush,
        output ready_o, valid_o, data_o, lane_valid_o, count_o
    );
endinterface

// File: rtl/pipe_latch.sv
// Inter-stage pipeline latch: LANES x WIDTH payload, valid/ready with a 2-entry skid buffer.
// Optional build macro PIPE_LATCH_ZERO_FLUSH_EN zeroes payload and lane masks on flush.
module pipe_latch #(
    parameter int WIDTH = 96,
    parameter int LANES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    pipe_latch_if.slave bus
);
    localparam int DW = WIDTH * LANES;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [DW-1:0]    main_data_r;
    logic [DW-1:0]    skid_data_r;
    logic [LANES-1:0] main_lane_r;
    logic [LANES-1:0] skid_lane_r;

    logic ready_s;
    logic valid_s;
    logic in_fire_s;
    logic out_fire_s;
    logic load_main_in_s;
    logic load_main_skid_s;
    logic load_skid_s;
    logic clear_s;

    // ready_o never looks at ready_i, so no combinational path runs through the latch
    assign ready_s    = (state_r != ST_TWO) & ~bus.freeze & ~bus.flush & ~RST;
    assign valid_s    = (state_r != ST_EMPTY) & ~bus.freeze;
    assign in_fire_s  = bus.valid_i & ready_s;
    assign out_fire_s = valid_s & bus.ready_i & ~bus.flush;

    // Occupancy state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next occupancy: freeze holds, flush empties, otherwise follow the fires
    always_comb begin
        state_nxt_s = state_r;
        if (bus.freeze) begin
            state_nxt_s = state_r;
        end else if (bus.flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && !out_fire_s) begin
                        state_nxt_s = ST_TWO;
                    end else if (!in_fire_s && out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // Datapath load controls derived from the current state and fires
    always_comb begin
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        clear_s          = bus.flush & ~bus.freeze;
        if (!bus.freeze && !bus.flush) begin
            case (state_r)
                ST_EMPTY: begin
                    load_main_in_s = in_fire_s;
                end
                ST_ONE: begin
                    load_main_in_s = in_fire_s & out_fire_s;
                    load_skid_s    = in_fire_s & ~out_fire_s;
                end
                ST_TWO: begin
                    load_main_skid_s = out_fire_s;
                end
                default: begin
                    load_main_in_s   = 1'b0;
                    load_main_skid_s = 1'b0;
                    load_skid_s      = 1'b0;
                end
            endcase
        end else begin
            load_main_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_s      = 1'b0;
        end
    end

    // Head entry payload and lane mask
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            main_data_r <= {DW{1'b0}};
            main_lane_r <= {LANES{1'b0}};
`ifdef PIPE_LATCH_ZERO_FLUSH_EN
        end else if (clear_s) begin
            main_data_r <= {DW{1'b0}};
            main_lane_r <= {LANES{1'b0}};
`endif
        end else if (load_main_in_s) begin
            main_data_r <= bus.data_i;
            main_lane_r <= bus.lane_valid_i;
        end else if (load_main_skid_s) begin
            main_data_r <= skid_data_r;
            main_lane_r <= skid_lane_r;
        end else begin
            main_data_r <= main_data_r;
            main_lane_r <= main_lane_r;
        end
    end

    // Skid entry payload and lane mask
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            skid_data_r <= {DW{1'b0}};
            skid_lane_r <= {LANES{1'b0}};
`ifdef PIPE_LATCH_ZERO_FLUSH_EN
        end else if (clear_s) begin
            skid_data_r <= {DW{1'b0}};
            skid_lane_r <= {LANES{1'b0}};
`endif
        end else if (load_skid_s) begin
            skid_data_r <= bus.data_i;
            skid_lane_r <= bus.lane_valid_i;
        end else begin
            skid_data_r <= skid_data_r;
            skid_lane_r <= skid_lane_r;
        end
    end

    assign bus.ready_o      = ready_s;
    assign bus.valid_o      = valid_s;
    assign bus.data_o       = main_data_r;
    assign bus.lane_valid_o = main_lane_r;
    assign bus.count_o      = state_r;
endmodule
